i2c_bus_monitor: RTL and testbench
==================================

// Module: i2c_bus_monitor
// PURPOSE
//  Passive decoder on the translated I2C bus (the SCL/SDA pair the translator drives toward the slaves).
//  Recovers START, repeated START, address, data, ACK/NACK and STOP from the open-drain lines.
//  Pushes each event into a small first-word-fall-through FIFO read with a valid/ready handshake.
//  Flags a stuck bus (SCL held low) and FIFO overflow. Never drives the bus.
// PARAMETERS
//  SYNC_STAGES  2      input synchroniser depth per line, min 2
//  FILT_LEN     3      consecutive equal synchronised samples required before a filtered line changes
//  TOUT_CYC     96000  SCL-low cycles (non-IDLE) that declare a stuck bus, 1 ms at 96 MHz
//  IDLE_CYC     768    cycles of SCL=SDA=1 that release STUCK back to IDLE
//  FIFO_DEPTH   4      event FIFO entries, power of 2, >=2
// PORTS
//  iclk       in   1   system clock, 96 MHz
//  irst_n     in   1   asynchronous active-low reset
//  iscl       in   1   bus SCL as seen at pin, 1 = released
//  isda       in   1   bus SDA as seen at pin, 1 = released
//  iready     in   1   consumer accepts head event this cycle
//  iclr_ovf   in   1   one-cycle pulse, clears oovf
//  ovalid     out  1   FIFO not empty, head event on oev_*
//  oev_type   out  3   0 START, 1 RSTART, 2 ADDR, 3 DATA, 4 STOP, 5 TIMEOUT; 6,7 never produced
//  oev_data   out  8   ADDR/DATA: byte MSB-first, addr byte includes R/W in bit0; START/RSTART/STOP/TIMEOUT: bits of aborted byte in [3:0], else 0
//  oev_ack    out  1   ADDR/DATA: 1 = ACK (SDA low on 9th clock); 0 for all other types
//  orw        out  1   R/W bit of current transaction (1 = read), valid after ADDR event
//  obusy      out  1   state != IDLE
//  otimeout   out  1   state == STUCK
//  oovf       out  1   sticky: event lost because FIFO full
// BEHAVIOUR
//  Reset (async assert, sync deassert internally): sync/filter regs = 1, state IDLE, FIFO empty,
//   ovalid=0, oev_*=0, orw=0, obusy=0, otimeout=0, oovf=0, all counters 0.
//  Filter: scl_f/sda_f take new value only after FILT_LEN consecutive identical synchronised samples.
//  Detection on filtered lines, registered once:
//   START = sda_f 1->0 while scl_f=1; STOP = sda_f 0->1 while scl_f=1; bit sample = scl_f 0->1.
//  Latency: pin change to ovalid (FIFO empty) = SYNC_STAGES + FILT_LEN + 2 iclk cycles, exact.
//  FSM:
//   IDLE : START -> push START, bitcnt=0, -> ADDR. STOP ignored. Bit samples ignored.
//   ADDR : shift SDA on each sample, bitcnt 0..8; 9th sample = ACK; then push ADDR{byte,ack},
//          orw<=byte[0], bitcnt=0, -> DATA.
//   DATA : same framing, push DATA{byte,ack} per 9 samples, stay in DATA.
//   ADDR/DATA: START -> push RSTART{data[3:0]=bitcnt}, -> ADDR; STOP -> push STOP{bitcnt}, -> IDLE.
//   Any non-IDLE, non-STUCK: scl_f low for TOUT_CYC consecutive cycles -> push TIMEOUT{bitcnt}, -> STUCK.
//   STUCK: START -> push START, -> ADDR; scl_f=sda_f=1 for IDLE_CYC cycles -> IDLE (no event).
//  Partial byte is discarded on START/STOP/TIMEOUT; its bit count (0..8) reported in oev_data[3:0].
//  Simultaneous detection: START and STOP are mutually exclusive by construction; a bit sample and
//   START/STOP never coincide (different line edges); STOP wins over timeout expiry in same cycle.
//  SCL-low counter saturates; cleared on any scl_f=1 cycle. IDLE counter cleared when either line low.
//  FIFO: push when event && !full; pop when ovalid && iready. Full with push+pop same cycle: both happen,
//   no overflow. Full with push, no pop: event dropped, oovf<=1. iclr_ovf clears oovf; if a drop occurs
//   same cycle, oovf stays 1. Pointers wrap modulo FIFO_DEPTH. oev_* hold head entry stably while
//   ovalid && !iready; oev_*=0 when empty.
//  orw persists until next ADDR event or reset.
// TESTING
//  Write 0x50 addr, data 0xA5, ACKs, STOP, iready=1 -> START; ADDR 0xA0 ack1; DATA 0xA5 ack1; STOP 0; orw=0.
//  Read 0x50, 2 bytes, master NACK last, RSTART between -> START; ADDR 0xA1 ack1; DATA ack1; DATA ack0; STOP; orw=1.
//  SCL low for TOUT_CYC after 3 data bits -> TIMEOUT data=0x03, otimeout=1; lines high 768 cycles -> obusy=0.
//  iready=0, 7 events -> 4 stored, oovf=1, first 4 events read intact in order; iclr_ovf -> oovf=0.
//  SDA glitch 2 cycles wide while SCL high (FILT_LEN=3) -> no START/STOP event, state unchanged.
//  irst_n low mid-DATA byte -> all outputs 0 immediately, ovalid=0, next START decodes normally.

Source files
------------

// File: rtl/i2c_bus_monitor_if.sv
// Signal bundle between the I2C bus monitor and its surroundings: the observed bus
// lines, the event read handshake and the status flags.
interface i2c_bus_monitor_if;
  logic       iscl;
  logic       isda;
  logic       iready;
  logic       iclr_ovf;
  logic       ovalid;
  logic [2:0] oev_type;
  logic [7:0] oev_data;
  logic       oev_ack;
  logic       orw;
  logic       obusy;
  logic       otimeout;
  logic       oovf;

  // Environment side: drives the bus lines and consumes events.
  modport master (
    output iscl, isda, iready, iclr_ovf,
    input  ovalid, oev_type, oev_data, oev_ack, orw, obusy, otimeout, oovf
  );

  // Monitor side.
  modport slave (
    input  iscl, isda, iready, iclr_ovf,
    output ovalid, oev_type, oev_data, oev_ack, orw, obusy, otimeout, oovf
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronises and de-glitches SCL/SDA, decodes START,
// repeated START, address/data bytes with ACK, STOP and stuck-SCL timeouts, and
// queues each event in a small first-word-fall-through FIFO. Never drives the bus.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned TOUT_CYC    = 96000,
  parameter int unsigned IDLE_CYC    = 768,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic              iclk,
  input logic              irst_n,
  i2c_bus_monitor_if.slave bus
);

  localparam int unsigned FiltW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned ToutW = $clog2(TOUT_CYC + 1);
  localparam int unsigned IdleW = $clog2(IDLE_CYC + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILT_LEN - 1);
  localparam logic [ToutW-1:0] ToutMax = ToutW'(TOUT_CYC - 1);
  localparam logic [ToutW-1:0] ToutSat = ToutW'(TOUT_CYC);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_CYC - 1);
  localparam logic [IdleW-1:0] IdleSat = IdleW'(IDLE_CYC);

  localparam logic [2:0] EvStart   = 3'd0;
  localparam logic [2:0] EvRstart  = 3'd1;
  localparam logic [2:0] EvAddr    = 3'd2;
  localparam logic [2:0] EvData    = 3'd3;
  localparam logic [2:0] EvStop    = 3'd4;
  localparam logic [2:0] EvTimeout = 3'd5;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StStuck} state_e;

  // ---------------------------------------------------------------------------
  // Reset: asserted asynchronously, released synchronously to iclk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset release synchroniser.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Input synchronisers and glitch filter. Index 1 = SCL, index 0 = SDA.
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic [1:0]             line_s;
  logic [1:0]             line_f_q;
  logic [FiltW-1:0]       filt_cnt_q [2];
  logic                   scl_f;
  logic                   sda_f;

  // Metastability synchronisers on both lines; idle bus reads as released.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.iscl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.isda};
    end
  end

  assign line_s = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

  // Filtered line follows only after FILT_LEN consecutive differing samples.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      line_f_q      <= 2'b11;
      filt_cnt_q[0] <= '0;
      filt_cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (line_s[i] == line_f_q[i]) begin
          filt_cnt_q[i] <= '0;
        end else if (filt_cnt_q[i] == FiltMax) begin
          line_f_q[i]   <= line_s[i];
          filt_cnt_q[i] <= '0;
        end else begin
          filt_cnt_q[i] <= filt_cnt_q[i] + FiltW'(1);
        end
      end
    end
  end

  assign scl_f = line_f_q[1];
  assign sda_f = line_f_q[0];

  // ---------------------------------------------------------------------------
  // Registered line-condition detection.
  logic scl_p_q;
  logic sda_p_q;
  logic start_q;
  logic stop_q;
  logic sample_q;
  logic bit_q;

  // One-cycle pulses for START, STOP and SCL rising edge (with the SDA bit).
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q  <= 1'b1;
      sda_p_q  <= 1'b1;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      scl_p_q  <= scl_f;
      sda_p_q  <= sda_f;
      start_q  <= scl_f & scl_p_q & sda_p_q & ~sda_f;
      stop_q   <= scl_f & scl_p_q & ~sda_p_q & sda_f;
      sample_q <= ~scl_p_q & scl_f;
      bit_q    <= sda_f;
    end
  end

  // ---------------------------------------------------------------------------
  // SCL-low and bus-idle cycle counters, both saturating.
  logic [ToutW-1:0] low_cnt_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic             tout_hit;
  logic             idle_hit;

  // Count consecutive SCL-low cycles and consecutive both-lines-high cycles.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      if (scl_f) begin
        low_cnt_q <= '0;
      end else if (low_cnt_q != ToutSat) begin
        low_cnt_q <= low_cnt_q + ToutW'(1);
      end
      if (!(scl_f && sda_f)) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IdleSat) begin
        idle_cnt_q <= idle_cnt_q + IdleW'(1);
      end
    end
  end

  // Fires once, on the TOUT_CYC-th consecutive low cycle.
  assign tout_hit = ~scl_f & (low_cnt_q == ToutMax);
  assign idle_hit = scl_f & sda_f & (idle_cnt_q == IdleMax);

  // ---------------------------------------------------------------------------
  // Protocol FSM.
  state_e     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       hi_bit_q, hi_bit_d;
  logic [3:0] abort_cnt;
  logic       ev_push;
  logic [2:0] ev_type;
  logic [7:0] ev_data;
  logic       ev_ack;

  // FSM state and byte-assembly registers.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      hi_bit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      hi_bit_q <= hi_bit_d;
    end
  end

  // Next state, byte framing and event generation.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    rw_d     = rw_q;
    hi_bit_d = hi_bit_q;
    ev_push  = 1'b0;
    ev_type  = EvStart;
    ev_data  = '0;
    ev_ack   = 1'b0;

    // A bit sampled in the SCL-high phase that a START/STOP lands in is not data
    // (Sr and P always raise SCL first), so it is left out of the aborted count.
    if (hi_bit_q && (bitcnt_q != 4'd0)) begin
      abort_cnt = bitcnt_q - 4'd1;
    end else begin
      abort_cnt = bitcnt_q;
    end

    if (sample_q) begin
      hi_bit_d = 1'b1;
    end else if (!scl_p_q) begin
      hi_bit_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          ev_push  = 1'b1;
          ev_type  = EvStart;
          bitcnt_d = '0;
          state_d  = StAddr;
        end
      end
      StAddr, StData: begin
        if (start_q) begin
          ev_push  = 1'b1;
          ev_type  = EvRstart;
          ev_data  = {4'd0, abort_cnt};
          bitcnt_d = '0;
          state_d  = StAddr;
        end else if (stop_q) begin
          ev_push  = 1'b1;
          ev_type  = EvStop;
          ev_data  = {4'd0, abort_cnt};
          bitcnt_d = '0;
          state_d  = StIdle;
        end else if (tout_hit) begin
          ev_push  = 1'b1;
          ev_type  = EvTimeout;
          ev_data  = {4'd0, abort_cnt};
          bitcnt_d = '0;
          state_d  = StStuck;
        end else if (sample_q) begin
          if (bitcnt_q == 4'd8) begin
            // Ninth clock carries the ACK (SDA low = ACK).
            ev_push  = 1'b1;
            ev_type  = (state_q == StAddr) ? EvAddr : EvData;
            ev_data  = shift_q;
            ev_ack   = ~bit_q;
            bitcnt_d = '0;
            if (state_q == StAddr) begin
              rw_d = shift_q[0];
            end
            state_d = StData;
          end else begin
            shift_d  = {shift_q[6:0], bit_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      StStuck: begin
        if (start_q) begin
          ev_push  = 1'b1;
          ev_type  = EvStart;
          bitcnt_d = '0;
          state_d  = StAddr;
        end else if (idle_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event FIFO, first-word fall-through. Entry = {type, data, ack}.
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [PtrW:0] wptr_q;
  logic [PtrW:0] rptr_q;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          ovf_q;
  logic [11:0]   head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop   = ~empty & bus.iready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = ev_push & (~full | pop);
  assign drop  = ev_push & full & ~pop;

  // FIFO storage and pointers.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q[PtrW-1:0]] <= {ev_type, ev_data, ev_ack};
        wptr_q <= wptr_q + (PtrW + 1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (PtrW + 1)'(1);
      end
    end
  end

  // Sticky overflow flag; a drop in the clear cycle keeps it set.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.iclr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign head = empty ? 12'd0 : mem_q[rptr_q[PtrW-1:0]];

  assign bus.ovalid   = ~empty;
  assign bus.oev_type = head[11:9];
  assign bus.oev_data = head[8:1];
  assign bus.oev_ack  = head[0];
  assign bus.orw      = rw_q;
  assign bus.obusy    = (state_q != StIdle);
  assign bus.otimeout = (state_q == StStuck);
  assign bus.oovf     = ovf_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: table-driven single-byte transactions
// plus hand-written sequences for latency, repeated START, timeout, overflow,
// glitch rejection and reset. Expected events go to a queue when stimulus is
// driven and are compared when the DUT presents them.
module tb_i2c_bus_monitor;
  localparam int unsigned TOUT = 1000;
  localparam int unsigned IDLE = 768;
  localparam int          HC   = 8;

  localparam logic [2:0] EvStart   = 3'd0;
  localparam logic [2:0] EvRstart  = 3'd1;
  localparam logic [2:0] EvAddr    = 3'd2;
  localparam logic [2:0] EvData    = 3'd3;
  localparam logic [2:0] EvStop    = 3'd4;
  localparam logic [2:0] EvTimeout = 3'd5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  i2c_bus_monitor_if bus ();

  i2c_bus_monitor #(
    .SYNC_STAGES(2),
    .FILT_LEN   (3),
    .TOUT_CYC   (TOUT),
    .IDLE_CYC   (IDLE),
    .FIFO_DEPTH (4)
  ) dut (
    .iclk  (clk),
    .irst_n(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] t;
    logic [7:0] d;
    logic       a;
  } ev_t;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       aack;
    logic       dack;
    logic [7:0] exp_addr;
    logic       exp_rw;
  } vec_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard: compare every event the consumer accepts.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && bus.ovalid && bus.iready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got type=%0d data=%0h ack=%0d want=none",
                 bus.oev_type, bus.oev_data, bus.oev_ack);
      end else begin
        e = exp_q.pop_front();
        check("ev_type", 32'(bus.oev_type), 32'(e.t));
        check("ev_data", 32'(bus.oev_data), 32'(e.d));
        check("ev_ack", 32'(bus.oev_ack), 32'(e.a));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [2:0] t, input logic [7:0] d, input logic a);
    ev_t e;
    e.t = t;
    e.d = d;
    e.a = a;
    exp_q.push_back(e);
  endtask

  // START from idle, or repeated START when SCL is low.
  task automatic i2c_start();
    bus.isda = 1'b1;
    cyc(HC);
    bus.iscl = 1'b1;
    cyc(HC);
    bus.isda = 1'b0;
    cyc(HC);
    bus.iscl = 1'b0;
    cyc(HC);
  endtask

  task automatic i2c_stop();
    bus.iscl = 1'b0;
    cyc(HC);
    bus.isda = 1'b0;
    cyc(HC);
    bus.iscl = 1'b1;
    cyc(HC);
    bus.isda = 1'b1;
    cyc(HC);
  endtask

  task automatic send_bit(input logic b);
    bus.isda = b;
    cyc(HC);
    bus.iscl = 1'b1;
    cyc(HC);
    bus.iscl = 1'b0;
    cyc(HC);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(~ack);
  endtask

  // Wait (bounded) for the scoreboard to consume every expected event.
  task automatic drain(input string name);
    int n;
    n = 0;
    cyc(12);
    while (exp_q.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   n;

    vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA0, 1'b0};
    vecs[1] = '{7'h50, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA1, 1'b1};
    vecs[2] = '{7'h7F, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0};
    vecs[3] = '{7'h01, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h03, 1'b1};

    rst_n        = 1'b0;
    bus.iscl     = 1'b1;
    bus.isda     = 1'b1;
    bus.iready   = 1'b1;
    bus.iclr_ovf = 1'b0;
    cyc(3);
    check("rst_ovalid", 32'(bus.ovalid), 0);
    check("rst_ev_type", 32'(bus.oev_type), 0);
    check("rst_ev_data", 32'(bus.oev_data), 0);
    check("rst_ev_ack", 32'(bus.oev_ack), 0);
    check("rst_orw", 32'(bus.orw), 0);
    check("rst_obusy", 32'(bus.obusy), 0);
    check("rst_otimeout", 32'(bus.otimeout), 0);
    check("rst_oovf", 32'(bus.oovf), 0);
    rst_n = 1'b1;
    cyc(6);
    check("post_rst_obusy", 32'(bus.obusy), 0);

    // Pin change to ovalid: SYNC_STAGES + FILT_LEN + 2 = 7 clock edges.
    expect_ev(EvStart, 8'h00, 1'b0);
    bus.isda = 1'b0;
    repeat (7) @(negedge clk);
    check("latency_6_edges", 32'(bus.ovalid), 0);
    @(negedge clk);
    check("latency_7_edges", 32'(bus.ovalid), 1);
    cyc(HC);
    expect_ev(EvStop, 8'h00, 1'b0);
    i2c_stop();
    drain("latency_drain");

    // Table-driven single-byte transactions.
    for (int v = 0; v < 4; v++) begin
      expect_ev(EvStart, 8'h00, 1'b0);
      i2c_start();
      expect_ev(EvAddr, vecs[v].exp_addr, vecs[v].aack);
      send_byte({vecs[v].addr, vecs[v].rw}, vecs[v].aack);
      expect_ev(EvData, vecs[v].data, vecs[v].dack);
      send_byte(vecs[v].data, vecs[v].dack);
      expect_ev(EvStop, 8'h00, 1'b0);
      i2c_stop();
      drain($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_orw", v), 32'(bus.orw), 32'(vecs[v].exp_rw));
      check($sformatf("vec%0d_obusy", v), 32'(bus.obusy), 0);
      check($sformatf("vec%0d_empty_type", v), 32'(bus.oev_type), 0);
    end

    // Register read: write pointer, repeated START, two reads, NACK on the last.
    expect_ev(EvStart, 8'h00, 1'b0);
    i2c_start();
    expect_ev(EvAddr, 8'hA0, 1'b1);
    send_byte(8'hA0, 1'b1);
    expect_ev(EvData, 8'h10, 1'b1);
    send_byte(8'h10, 1'b1);
    expect_ev(EvRstart, 8'h00, 1'b0);
    i2c_start();
    expect_ev(EvAddr, 8'hA1, 1'b1);
    send_byte(8'hA1, 1'b1);
    expect_ev(EvData, 8'h5A, 1'b1);
    send_byte(8'h5A, 1'b1);
    expect_ev(EvData, 8'hC3, 1'b0);
    send_byte(8'hC3, 1'b0);
    expect_ev(EvStop, 8'h00, 1'b0);
    i2c_stop();
    drain("read_drain");
    check("read_orw", 32'(bus.orw), 1);

    // SCL held low after 3 data bits.
    expect_ev(EvStart, 8'h00, 1'b0);
    i2c_start();
    expect_ev(EvAddr, 8'hA0, 1'b1);
    send_byte(8'hA0, 1'b1);
    expect_ev(EvTimeout, 8'h03, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    n = 0;
    while (!bus.otimeout && n < int'(TOUT) + 100) begin
      cyc(1);
      n++;
    end
    check("timeout_flag", 32'(bus.otimeout), 1);
    check("timeout_busy", 32'(bus.obusy), 1);
    drain("timeout_drain");
    bus.isda = 1'b1;
    cyc(HC);
    bus.iscl = 1'b1;
    n = 0;
    while (bus.obusy && n < int'(IDLE) + 100) begin
      cyc(1);
      n++;
    end
    check("stuck_not_early", 32'(n >= int'(IDLE)), 1);
    check("stuck_release_busy", 32'(bus.obusy), 0);
    check("stuck_release_tout", 32'(bus.otimeout), 0);

    // Overflow: 7 events with no consumer, only the first 4 survive.
    bus.iready = 1'b0;
    expect_ev(EvStart, 8'h00, 1'b0);
    i2c_start();
    expect_ev(EvAddr, 8'hA0, 1'b1);
    send_byte(8'hA0, 1'b1);
    expect_ev(EvData, 8'h11, 1'b1);
    send_byte(8'h11, 1'b1);
    expect_ev(EvData, 8'h22, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    i2c_stop();
    i2c_start();
    cyc(20);
    check("ovf_set", 32'(bus.oovf), 1);
    check("ovf_valid", 32'(bus.ovalid), 1);
    check("ovf_head_held", 32'(bus.oev_type), 32'(EvStart));
    bus.iready = 1'b1;
    drain("ovf_drain");
    check("ovf_sticky", 32'(bus.oovf), 1);
    bus.iclr_ovf = 1'b1;
    cyc(1);
    bus.iclr_ovf = 1'b0;
    check("ovf_cleared", 32'(bus.oovf), 0);
    expect_ev(EvStop, 8'h00, 1'b0);
    i2c_stop();
    drain("ovf_stop_drain");

    // Two-cycle SDA glitch with SCL high must be filtered out.
    cyc(20);
    bus.isda = 1'b0;
    cyc(2);
    bus.isda = 1'b1;
    cyc(30);
    check("glitch_no_event", 32'(bus.ovalid), 0);
    check("glitch_idle", 32'(bus.obusy), 0);

    // Reset in the middle of a data byte.
    expect_ev(EvStart, 8'h00, 1'b0);
    i2c_start();
    expect_ev(EvAddr, 8'hA1, 1'b1);
    send_byte(8'hA1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    drain("pre_reset_drain");
    check("pre_reset_orw", 32'(bus.orw), 1);
    check("pre_reset_busy", 32'(bus.obusy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_orw", 32'(bus.orw), 0);
    check("mid_rst_busy", 32'(bus.obusy), 0);
    check("mid_rst_valid", 32'(bus.ovalid), 0);
    bus.iscl = 1'b1;
    bus.isda = 1'b1;
    cyc(5);
    rst_n = 1'b1;
    cyc(6);
    expect_ev(EvStart, 8'h00, 1'b0);
    i2c_start();
    expect_ev(EvAddr, 8'hA0, 1'b1);
    send_byte(8'hA0, 1'b1);
    expect_ev(EvData, 8'h77, 1'b1);
    send_byte(8'h77, 1'b1);
    expect_ev(EvStop, 8'h00, 1'b0);
    i2c_stop();
    drain("post_reset_drain");
    check("post_reset_orw", 32'(bus.orw), 0);
    check("post_reset_busy", 32'(bus.obusy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
